atm_button_conditioner: RTL and testbench

- Front-end stage feeding the ATM control FSM.
- Synchronises and debounces the three raw push-buttons and the 4-bit switch bank.
- Emits exactly one single-cycle command pulse per qualified press, with a switch snapshot taken in the same cycle.
- The FSM can therefore treat BTN3/BTN2/BTN1 as one-shot events and SW as stable data.

---
 rtl/atm_pkg.sv | 13 +
 rtl/atm_debounce.sv | 51 +++++
 rtl/atm_button_conditioner.sv | 66 ++++++
 tb/tb_atm_button_conditioner.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// atm_pkg: shared constants and debounce state encoding for the ATM button front-end.
package atm_pkg;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
    localparam int BTN3_I = 2;
    localparam int BTN2_I = 1;
    localparam int BTN1_I = 0;
    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } db_state_e;
endpackage

// File: rtl/atm_debounce.sv
// atm_debounce: two-flop synchroniser plus level debounce FSM for one push-button.
module atm_debounce
    import atm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o
);
    // Entering a WAIT state already counts one sample, so the flip happens on the Nth agreeing sample.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 2);
    logic [1:0] sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    db_state_e state_q, state_d;
    logic sync;
    assign sync = sync_q[1];
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            state_q <= STABLE_HI;
        end else begin
            sync_q  <= {sync_q[0], raw_i};
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            STABLE_LO: state_d = sync ? WAIT_HI : STABLE_LO;
            WAIT_HI: begin
                if (!sync) state_d = STABLE_LO;
                else if (cnt_q == LAST) state_d = STABLE_HI;
                else cnt_d = cnt_q + 1'b1;
            end
            STABLE_HI: state_d = sync ? STABLE_HI : WAIT_LO;
            WAIT_LO: begin
                if (sync) state_d = STABLE_HI;
                else if (cnt_q == LAST) state_d = STABLE_LO;
                else cnt_d = cnt_q + 1'b1;
            end
            default: state_d = STABLE_HI;
        endcase
    end
    assign level_o = (state_q == STABLE_HI) || (state_q == WAIT_LO);
endmodule

// File: rtl/atm_button_conditioner.sv
// atm_button_conditioner: debounces three buttons into one-shot command pulses
// with a synchronised switch snapshot taken on the same edge.
module atm_button_conditioner
    import atm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn3_raw,
    input  logic       btn2_raw,
    input  logic       btn1_raw,
    input  logic [3:0] sw_raw,
    input  logic       inhibit,
    output logic       btn3_pulse,
    output logic       btn2_pulse,
    output logic       btn1_pulse,
    output logic [3:0] sw_snap,
    output logic       busy
);
    logic [2:0] raw, lvl, lvl_prev_q, rise, qual, win, pulse_q;
    logic [3:0] sw_s1_q, sw_s2_q, sw_snap_q;
    assign raw = {btn3_raw, btn2_raw, btn1_raw};
    for (genvar b = 0; b < 3; b++) begin : g_db
        atm_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W(CNT_W)
        ) u_db (
            .clk(clk),
            .rst(rst),
            .raw_i(raw[b]),
            .level_o(lvl[b])
        );
    end
    // A rise only counts if no other button was already down; losers of a tie are dropped.
    always_comb begin
        rise = lvl & ~lvl_prev_q;
        qual = '0;
        for (int i = 0; i < 3; i++)
            qual[i] = rise[i] && !inhibit && !(|(lvl_prev_q & ~(3'b001 << i)));
        win = qual[BTN3_I] ? 3'b001 << BTN3_I :
              qual[BTN2_I] ? 3'b001 << BTN2_I :
              qual[BTN1_I] ? 3'b001 << BTN1_I : 3'b000;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
            lvl_prev_q <= '1;
            pulse_q    <= '0;
            sw_snap_q  <= '0;
        end else begin
            sw_s1_q    <= sw_raw;
            sw_s2_q    <= sw_s1_q;
            lvl_prev_q <= lvl;
            pulse_q    <= win;
            if (|win) sw_snap_q <= sw_s2_q;
        end
    end
    assign btn3_pulse = pulse_q[BTN3_I];
    assign btn2_pulse = pulse_q[BTN2_I];
    assign btn1_pulse = pulse_q[BTN1_I];
    assign sw_snap    = sw_snap_q;
    assign busy       = |lvl;
endmodule

// File: tb/tb_atm_button_conditioner.sv
// tb_atm_button_conditioner: directed vector table plus randomized run against a run-length reference model.
module tb_atm_button_conditioner;
    localparam int D = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn3_raw = 1'b0, btn2_raw = 1'b0, btn1_raw = 1'b0, inhibit = 1'b0;
    logic [3:0] sw_raw = 4'h0;
    logic btn3_pulse, btn2_pulse, btn1_pulse, busy;
    logic [3:0] sw_snap;
    int n_chk = 0;
    int n_fail = 0;
    int np = 0;

    atm_button_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst),
        .btn3_raw(btn3_raw), .btn2_raw(btn2_raw), .btn1_raw(btn1_raw),
        .sw_raw(sw_raw), .inhibit(inhibit),
        .btn3_pulse(btn3_pulse), .btn2_pulse(btn2_pulse), .btn1_pulse(btn1_pulse),
        .sw_snap(sw_snap), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: raw delayed two samples; level flips after D consecutive disagreeing samples.
    bit [2:0] m_r1, m_r2, m_lvl, m_prev, m_pulse;
    int m_run[3];
    bit [3:0] m_sw1, m_sw2, m_snap;

    typedef struct {
        bit       rst;
        bit [2:0] btn;
        bit [3:0] sw;
        bit       inh;
        int       n;
        bit [2:0] pulse;
        bit [3:0] snap;
        bit       busy;
        int       np;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        bit [2:0] raw, win, n_lvl;
        bit [3:0] n_snap;
        int n_run[3];
        raw = {btn3_raw, btn2_raw, btn1_raw};
        win = 3'b000;
        n_lvl = m_lvl;
        n_snap = m_snap;
        if (rst) begin
            n_lvl = 3'b111;
            n_snap = 4'h0;
            for (int i = 0; i < 3; i++) n_run[i] = 0;
        end else begin
            for (int i = 2; i >= 0; i--)
                if (win == 3'b000 && m_lvl[i] && !m_prev[i] && !inhibit && (m_prev & ~(3'b001 << i)) == 3'b000)
                    win = 3'b001 << i;
            if (win != 3'b000) n_snap = m_sw2;
            for (int i = 0; i < 3; i++) begin
                n_run[i] = (m_r2[i] != m_lvl[i]) ? m_run[i] + 1 : 0;
                if (n_run[i] == D) begin
                    n_lvl[i] = ~m_lvl[i];
                    n_run[i] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        m_prev  = rst ? 3'b111 : m_lvl;
        m_lvl   = n_lvl;
        m_pulse = win;
        m_snap  = n_snap;
        m_r2    = rst ? 3'b000 : m_r1;
        m_r1    = rst ? 3'b000 : raw;
        m_sw2   = rst ? 4'h0 : m_sw1;
        m_sw1   = rst ? 4'h0 : sw_raw;
        for (int i = 0; i < 3; i++) m_run[i] = n_run[i];
        np += int'(btn3_pulse) + int'(btn2_pulse) + int'(btn1_pulse);
        check("model", {24'h0, btn3_pulse, btn2_pulse, btn1_pulse, sw_snap, busy},
                       {24'h0, m_pulse, m_snap, |m_lvl});
    endtask

    task automatic add(input bit r, input bit [2:0] b, input bit [3:0] s, input bit ih, input int n,
                       input bit [2:0] p, input bit [3:0] sn, input bit bz, input int c);
        vec_t v;
        v = '{rst: r, btn: b, sw: s, inh: ih, n: n, pulse: p, snap: sn, busy: bz, np: c};
        tbl.push_back(v);
    endtask

    initial begin
        // reset, all low
        add(1, 3'b000, 4'h0, 0, 3, 3'b000, 4'h0, 1, 0);
        add(0, 3'b000, 4'h0, 0, 1, 3'b000, 4'h0, 1, 0);
        add(0, 3'b000, 4'h0, 0, 5, 3'b000, 4'h0, 0, 0);
        // clean btn3 press, snapshot holds after sw changes
        add(0, 3'b100, 4'hA, 0, 6, 3'b000, 4'h0, 1, 0);
        add(0, 3'b100, 4'hA, 0, 1, 3'b100, 4'hA, 1, 1);
        add(0, 3'b100, 4'h5, 0, 13, 3'b000, 4'hA, 1, 0);
        add(0, 3'b000, 4'h5, 0, 6, 3'b000, 4'hA, 0, 0);
        // btn2 bounce then hold
        add(0, 3'b010, 4'h5, 0, 1, 3'b000, 4'hA, 0, 0);
        add(0, 3'b000, 4'h5, 0, 1, 3'b000, 4'hA, 0, 0);
        add(0, 3'b010, 4'h5, 0, 1, 3'b000, 4'hA, 0, 0);
        add(0, 3'b000, 4'h5, 0, 1, 3'b000, 4'hA, 0, 0);
        add(0, 3'b010, 4'h5, 0, 1, 3'b000, 4'hA, 0, 0);
        add(0, 3'b000, 4'h5, 0, 1, 3'b000, 4'hA, 0, 0);
        add(0, 3'b010, 4'h5, 0, 6, 3'b000, 4'hA, 1, 0);
        add(0, 3'b010, 4'h5, 0, 1, 3'b010, 4'h5, 1, 1);
        add(0, 3'b010, 4'h5, 0, 10, 3'b000, 4'h5, 1, 0);
        add(0, 3'b000, 4'h5, 0, 6, 3'b000, 4'h5, 0, 0);
        // simultaneous btn3/btn1, loser needs re-press
        add(0, 3'b101, 4'hC, 0, 6, 3'b000, 4'h5, 1, 0);
        add(0, 3'b101, 4'hC, 0, 1, 3'b100, 4'hC, 1, 1);
        add(0, 3'b001, 4'hC, 0, 10, 3'b000, 4'hC, 1, 0);
        add(0, 3'b000, 4'hC, 0, 6, 3'b000, 4'hC, 0, 0);
        add(0, 3'b001, 4'hC, 0, 6, 3'b000, 4'hC, 1, 0);
        add(0, 3'b001, 4'hC, 0, 1, 3'b001, 4'hC, 1, 1);
        add(0, 3'b000, 4'hC, 0, 6, 3'b000, 4'hC, 0, 0);
        // inhibit drops the press, held through inhibit falling
        add(0, 3'b001, 4'h6, 1, 10, 3'b000, 4'hC, 1, 0);
        add(0, 3'b001, 4'h6, 0, 5, 3'b000, 4'hC, 1, 0);
        add(0, 3'b000, 4'h3, 0, 6, 3'b000, 4'hC, 0, 0);
        add(0, 3'b001, 4'h3, 0, 6, 3'b000, 4'hC, 1, 0);
        add(0, 3'b001, 4'h3, 0, 1, 3'b001, 4'h3, 1, 1);
        add(0, 3'b000, 4'h3, 0, 6, 3'b000, 4'h3, 0, 0);
        // btn2 held through reset
        add(0, 3'b010, 4'h3, 0, 2, 3'b000, 4'h3, 0, 0);
        add(1, 3'b010, 4'h3, 0, 3, 3'b000, 4'h0, 1, 0);
        add(0, 3'b010, 4'h3, 0, 12, 3'b000, 4'h0, 1, 0);
        add(0, 3'b000, 4'h3, 0, 5, 3'b000, 4'h0, 1, 0);
        add(0, 3'b000, 4'h3, 0, 1, 3'b000, 4'h0, 0, 0);
        add(0, 3'b010, 4'h9, 0, 6, 3'b000, 4'h0, 1, 0);
        add(0, 3'b010, 4'h9, 0, 1, 3'b010, 4'h9, 1, 1);
        add(0, 3'b000, 4'h9, 0, 6, 3'b000, 4'h9, 0, 0);

        foreach (tbl[k]) begin
            rst = tbl[k].rst;
            {btn3_raw, btn2_raw, btn1_raw} = tbl[k].btn;
            sw_raw = tbl[k].sw;
            inhibit = tbl[k].inh;
            np = 0;
            for (int c = 0; c < tbl[k].n; c++) step();
            check($sformatf("v%0d.pulse", k), {29'h0, btn3_pulse, btn2_pulse, btn1_pulse}, {29'h0, tbl[k].pulse});
            check($sformatf("v%0d.snap", k), {28'h0, sw_snap}, {28'h0, tbl[k].snap});
            check($sformatf("v%0d.busy", k), {31'h0, busy}, {31'h0, tbl[k].busy});
            check($sformatf("v%0d.npulses", k), np, tbl[k].np);
        end

        rst = 1'b0;
        inhibit = 1'b0;
        {btn3_raw, btn2_raw, btn1_raw} = 3'b000;
        np = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 13) == 0) btn3_raw = ~btn3_raw;
            if ($urandom_range(0, 13) == 0) btn2_raw = ~btn2_raw;
            if ($urandom_range(0, 13) == 0) btn1_raw = ~btn1_raw;
            if ($urandom_range(0, 23) == 0) inhibit = ~inhibit;
            if ($urandom_range(0, 3) == 0) sw_raw = 4'($urandom);
            rst = ($urandom_range(0, 599) == 0);
            step();
        end
        check("rand_pulses_seen", {31'h0, np > 0}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
